pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the multi-cycle RISC-V core; the successor to the fixed 32-bit, 4-cycle PC. It holds the architectural PC and steps it once every CPI cycles through a phase counter. It accepts redirects (jump/branch/trap), stall and debug halt/resume. Redirect targets can optionally be checked for alignment. It feeds the instruction memory address and the fetch/decode/execute phase enables.

---
 rtl/pc_sequencer_pkg.sv | 20 ++
 rtl/pc_sequencer_phase.sv | 24 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helper functions for the program-counter sequencer.
package pc_sequencer_pkg;

    typedef enum logic {
        PCS_RUN,
        PCS_HALTED
    } pcs_state_e;

    // Phase counter width; never zero, so CPI = 1 still gets a 1-bit port.
    function automatic int unsigned phase_width(input int unsigned cpi);
        return (cpi <= 2) ? 1 : $clog2(cpi);
    endfunction

    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned inc);
        logic [63:0] mask;
        mask = 64'(inc - 1);
        return (addr & mask) == '0;
    endfunction

endpackage

// File: rtl/pc_sequencer_phase.sv
// Modulo-CPI phase counter; wrap marks the last cycle of an instruction.
module pc_phase_counter #(
    parameter int unsigned CPI = 4,
    parameter int unsigned PW  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    output logic [PW-1:0] phase,
    output logic          wrap
);

    assign wrap = (phase == PW'(CPI - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            phase <= '0;
        end else if (en) begin
            phase <= wrap ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Parametrised PC sequencer: steps the PC every CPI cycles, handles redirect,
// stall and debug halt/resume. Optional alignment check: PC_SEQUENCER_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     CPI       = 4,
    parameter int unsigned     INC       = 1,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_target,
    input  logic                          halt_req,
    input  logic                          resume,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               pc_seq,
    output logic [phase_width(CPI)-1:0]   phase,
    output logic                          step,
    output logic                          running,
    output logic                          fault,
    output logic [XLEN-1:0]               fault_addr
);

    localparam int unsigned PW = phase_width(CPI);

    pcs_state_e state;
    logic       wrap;
    logic       misaligned;
    logic       redirect_ok;
    logic       phase_clear;
    logic       phase_en;
    logic       resume_now;

`ifdef PC_SEQUENCER_ALIGN_CHECK_EN
    assign misaligned = redirect_valid && !is_aligned(64'(redirect_target), INC);
`else
    assign misaligned = 1'b0;
`endif

    assign running     = (state == PCS_RUN);
    assign redirect_ok = redirect_valid && !misaligned;
    assign resume_now  = !running && resume;
    assign pc_seq      = pc + XLEN'(INC);
    assign step        = running && wrap && !stall && !redirect_valid;

    // A rejected redirect must leave phase untouched, hence !redirect_valid
    // in the enable rather than relying on the clear.
    assign phase_en    = running && !stall && !redirect_valid;
    assign phase_clear = redirect_ok || resume_now;

    pc_phase_counter #(
        .CPI (CPI),
        .PW  (PW)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .clear (phase_clear),
        .en    (phase_en),
        .phase (phase),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_VEC;
            state <= PCS_RUN;
        end else if (misaligned) begin
            state <= PCS_HALTED;
        end else if (redirect_ok) begin
            pc <= redirect_target;
            if (resume_now) begin
                state <= PCS_RUN;
            end
        end else if (step) begin
            pc <= pc_seq;
            if (halt_req) begin
                state <= PCS_HALTED;
            end
        end else if (resume_now) begin
            state <= PCS_RUN;
        end
    end

`ifdef PC_SEQUENCER_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            fault <= misaligned;
            if (misaligned) begin
                fault_addr <= redirect_target;
            end
        end
    end
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (32-bit word-addressed and
// 8-bit byte-addressed instances); alignment checks follow PC_SEQUENCER_ALIGN_CHECK_EN.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance A: XLEN=32, CPI=4, INC=1, RESET_VEC=0x100
    logic        rst_a, stall_a, rv_a, halt_a, resume_a;
    logic [31:0] tgt_a, pc_a, pcs_a, faddr_a;
    logic [1:0]  phase_a;
    logic        step_a, run_a, fault_a;

    pc_sequencer #(
        .XLEN      (32),
        .CPI       (4),
        .INC       (1),
        .RESET_VEC (32'h100)
    ) u_dut_a (
        .clk             (clk),
        .rst             (rst_a),
        .stall           (stall_a),
        .redirect_valid  (rv_a),
        .redirect_target (tgt_a),
        .halt_req        (halt_a),
        .resume          (resume_a),
        .pc              (pc_a),
        .pc_seq          (pcs_a),
        .phase           (phase_a),
        .step            (step_a),
        .running         (run_a),
        .fault           (fault_a),
        .fault_addr      (faddr_a)
    );

    // Instance B: XLEN=8, CPI=4, INC=4, RESET_VEC=0xF8
    logic       rst_b, stall_b, rv_b, halt_b, resume_b;
    logic [7:0] tgt_b, pc_b, pcs_b, faddr_b;
    logic [1:0] phase_b;
    logic       step_b, run_b, fault_b;

    pc_sequencer #(
        .XLEN      (8),
        .CPI       (4),
        .INC       (4),
        .RESET_VEC (8'hF8)
    ) u_dut_b (
        .clk             (clk),
        .rst             (rst_b),
        .stall           (stall_b),
        .redirect_valid  (rv_b),
        .redirect_target (tgt_b),
        .halt_req        (halt_b),
        .resume          (resume_b),
        .pc              (pc_b),
        .pc_seq          (pcs_b),
        .phase           (phase_b),
        .step            (step_b),
        .running         (run_b),
        .fault           (fault_b),
        .fault_addr      (faddr_b)
    );

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1; stall_a = 0; rv_a = 0; tgt_a = '0; halt_a = 0; resume_a = 0;
        rst_b = 1; stall_b = 0; rv_b = 0; tgt_b = '0; halt_b = 0; resume_b = 0;
        cyc(2);
        rst_a = 0;

        // Reset state
        check("rst_pc", pc_a, 64'h100);
        check("rst_phase", phase_a, 0);
        check("rst_running", run_a, 1);
        check("rst_fault", fault_a, 0);
        check("rst_fault_addr", faddr_a, 0);
        check("rst_pc_seq", pcs_a, 64'h101);

        // Sequential stepping: step only on phase 3
        for (int i = 0; i < 8; i++) begin
            check("seq_step", step_a, (i % 4 == 3) ? 1 : 0);
            cyc();
            if (i == 3) check("seq_pc_c4", pc_a, 64'h101);
        end
        check("seq_pc_c8", pc_a, 64'h102);
        check("seq_phase_c8", phase_a, 0);

        // Redirect in phase 2 with stall held high
        cyc(2);
        check("rd_phase_before", phase_a, 2);
        stall_a = 1; rv_a = 1; tgt_a = 32'h40;
        check("rd_step_suppressed", step_a, 0);
        cyc();
        stall_a = 0; rv_a = 0;
        check("rd_pc", pc_a, 64'h40);
        check("rd_phase", phase_a, 0);
        cyc(2);
        check("rd_no_early_step", step_a, 0);
        cyc();
        check("rd_step_3_later", step_a, 1);
        cyc();
        check("rd_pc_after_step", pc_a, 64'h41);

        // Stall freezes phase and pc
        cyc();
        stall_a = 1;
        check("stall_step", step_a, 0);
        cyc(3);
        check("stall_phase", phase_a, 1);
        check("stall_pc", pc_a, 64'h41);
        stall_a = 0;

        // Halt requested from phase 1; completes the boundary instruction
        halt_a = 1;
        cyc();
        check("halt_phase2_running", run_a, 1);
        cyc();
        check("halt_boundary_step", step_a, 1);
        cyc();
        check("halt_pc", pc_a, 64'h42);
        check("halt_running", run_a, 0);
        stall_a = 1;
        cyc(2);
        check("halted_pc_frozen", pc_a, 64'h42);
        check("halted_phase", phase_a, 0);
        check("halted_step", step_a, 0);
        halt_a = 0; stall_a = 0;

        // Debugger PC write while halted
        rv_a = 1; tgt_a = 32'h20;
        cyc();
        rv_a = 0;
        check("halted_rd_pc", pc_a, 64'h20);
        check("halted_rd_running", run_a, 0);
        resume_a = 1;
        cyc();
        resume_a = 0;
        check("resume_running", run_a, 1);
        check("resume_phase", phase_a, 0);
        cyc(2);
        check("resume_phase2", phase_a, 2);

        // Reset mid-phase together with a redirect: redirect is dropped
        rst_a = 1; rv_a = 1; tgt_a = 32'h77;
        cyc();
        rst_a = 0; rv_a = 0;
        check("rst_mid_pc", pc_a, 64'h100);
        check("rst_mid_phase", phase_a, 0);
        check("rst_mid_running", run_a, 1);

        // INC=1 never faults, even with the check enabled
        rv_a = 1; tgt_a = 32'h23;
        cyc();
        rv_a = 0;
        check("inc1_pc", pc_a, 64'h23);
        check("inc1_fault", fault_a, 0);

        // Instance B: 8-bit byte-addressed wrap
        rst_b = 0;
        check("b_rst_pc", pc_b, 64'hF8);
        check("b_rst_pc_seq", pcs_b, 64'hFC);
        cyc(4);
        check("b_pc_fc", pc_b, 64'hFC);
        check("b_pc_seq_wrap", pcs_b, 64'h00);
        cyc(4);
        check("b_pc_wrap", pc_b, 64'h00);
        check("b_pc_seq_after", pcs_b, 64'h04);

        // Misaligned redirect
        rv_b = 1; tgt_b = 8'h22;
        cyc();
        rv_b = 0;
`ifdef PC_SEQUENCER_ALIGN_CHECK_EN
        check("b_mis_pc", pc_b, 64'h00);
        check("b_mis_fault", fault_b, 1);
        check("b_mis_fault_addr", faddr_b, 64'h22);
        check("b_mis_running", run_b, 0);
        cyc();
        check("b_mis_fault_pulse", fault_b, 0);
        check("b_mis_fault_addr_hold", faddr_b, 64'h22);
`else
        check("b_mis_pc", pc_b, 64'h22);
        check("b_mis_fault", fault_b, 0);
        check("b_mis_fault_addr", faddr_b, 64'h00);
        check("b_mis_running", run_b, 1);
        cyc();
        check("b_mis_fault_later", fault_b, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
